pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage CPU pipeline.
- Drives PC_write, each inter-stage register write enable (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the IF/ID/EXE flush inputs.
- Arbitrates four events: memory-wait freezes, multi-cycle EXE busy, load-use bubbles and branch-mispredict redirects.
- Keeps a pending-flush record across freezes, a memory-wait watchdog and performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- TIMEOUT, 1024, consecutive MEM_WAIT cycles before stall_timeout sets.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- IM_stall  in  1  instruction-memory access not complete.
- DM_stall  in  1  data-memory access not complete.
- EXE_busy  in  1  multi-cycle EXE unit (div/fp) still computing.
- EXE_mispredict  in  1  EXE resolved branch/jump mispredicted; may be a 1-cycle pulse.
- EXE_MemRead  in  1  instruction in EXE is a load.
- EXE_rd_addr  in  ADDR_W  destination register of the EXE instruction.
- ID_rs1_addr  in  ADDR_W  rs1 of the ID instruction.
- ID_rs2_addr  in  ADDR_W  rs2 of the ID instruction.
- ID_rs1_used  in  1  ID instruction reads rs1.
- ID_rs2_used  in  1  ID instruction reads rs2.
- PC_write  out  1  PC update enable.
- IF_ID_Reg_Write  out  1  IF/ID register enable.
- IF_Flush  out  1  bubble into IF/ID.
- ID_EXE_Reg_Write  out  1  ID/EXE register enable.
- ID_Flush  out  1  bubble into ID/EXE.
- EXE_MEM_Reg_Write  out  1  EXE/MEM register enable.
- EXE_Flush  out  1  bubble into EXE/MEM.
- MEM_WB_Reg_Write  out  1  MEM/WB register enable.
- stall_timeout  out  1  sticky watchdog flag.
- mem_stall_cnt  out  CNT_W  cycles spent in MEM_WAIT.
- lu_stall_cnt  out  CNT_W  load-use bubbles inserted.
- flush_cnt  out  CNT_W  redirects applied.

Behaviour:
- Control outputs are combinational from current inputs, state and flush_pend; zero latency.
- Counters, state, flush_pend and stall_timeout are registered.
- Reset (async, any cycle, including mid-stall):
  - state=RUN, flush_pend=0, counters=0, stall_timeout=0.
  - While rst=1, all *_Write=0 and all *_Flush=0.
- Definitions:
  - mem_stall = IM_stall | DM_stall.
  - load_use = EXE_MemRead & (EXE_rd_addr!=0) & ((ID_rs1_used & ID_rs1_addr==EXE_rd_addr) | (ID_rs2_used & ID_rs2_addr==EXE_rd_addr)).
  - redirect = EXE_mispredict | flush_pend.
- Priority, highest first, evaluated each cycle. Enables and flushes not named below are 1 and 0 respectively.
  1. mem_stall: every *_Write=0, every flush=0 (full freeze). If EXE_mispredict=1, set flush_pend next cycle.
  2. redirect: all *_Write=1, IF_Flush=1, ID_Flush=1, EXE_Flush=0. Clear flush_pend; flush_cnt+1.
  3. EXE_busy: PC_write=0, IF_ID_Reg_Write=0, ID_EXE_Reg_Write=0, EXE_MEM_Reg_Write=1 with EXE_Flush=1 (bubble into MEM), MEM_WB_Reg_Write=1.
  4. load_use: PC_write=0, IF_ID_Reg_Write=0, ID_EXE_Reg_Write=1 with ID_Flush=1, EXE_MEM/MEM_WB enables 1. lu_stall_cnt+1.
  5. Otherwise: all *_Write=1, all flushes 0.
- Redirect outranks load_use and EXE_busy: the ID/IF instructions are on the wrong path.
- A load_use coinciding with a redirect does not count.
- State machine:
  - RUN -> MEM_WAIT when mem_stall=1.
  - MEM_WAIT -> RUN when mem_stall=0. The exit cycle is evaluated in RUN priority order, so a pending flush applies on the first non-stalled cycle.
  - mem_stall_cnt increments every cycle mem_stall=1, including the entry cycle.
- Watchdog:
  - wait_cnt counts consecutive mem_stall cycles and clears when mem_stall=0.
  - When wait_cnt reaches TIMEOUT-1 while mem_stall=1, stall_timeout sets and stays 1 until reset.
  - The watchdog never alters the freeze.
- Counters wrap modulo 2^CNT_W.
- The last cycle of a load-use produces no further bubble: after the bubble, EXE holds a NOP, so EXE_MemRead=0.

Test Plan:
- Reset: assert rst asynchronously mid-MEM_WAIT with flush_pend=1 -> outputs go 0 immediately. After release: state RUN, flush_pend=0, counters 0, all *_Write=1 on the first idle cycle.
- Load-use: EXE_MemRead=1, EXE_rd_addr=5, ID_rs2_used=1, ID_rs2_addr=5 for one cycle -> PC_write=0, IF_ID_Reg_Write=0, ID_Flush=1, lu_stall_cnt=1. Same case with EXE_rd_addr=0 -> no stall.
- Mispredict during freeze: DM_stall=1 for 3 cycles, EXE_mispredict pulsed in cycle 1 -> all enables 0 for 3 cycles. Cycle 4: IF_Flush=ID_Flush=1, PC_write=1, flush_cnt=1. mem_stall_cnt=3.
- Mispredict plus load_use in the same cycle -> flushes asserted, PC_write=1, lu_stall_cnt unchanged.
- EXE_busy held 4 cycles -> PC/IF_ID/ID_EXE enables 0 and EXE_Flush=1 each cycle. Cycle 5: all enables 1.
- Watchdog: IM_stall=1 for TIMEOUT cycles -> stall_timeout rises at cycle TIMEOUT and stays 1 after IM_stall drops. Stall of TIMEOUT-1 cycles -> stall_timeout stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. It arbitrates
// memory-wait freezes, multi-cycle EXE busy, load-use bubbles and
// branch-mispredict redirects, and drives the PC and inter-stage register
// enables and flushes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   IM_stall, DM_stall       memory access not complete (full freeze)
//   EXE_busy                 multi-cycle EXE unit still computing
//   EXE_mispredict           EXE resolved a mispredicted branch/jump
//   EXE_MemRead, EXE_rd_addr load in EXE and its destination
//   ID_rs*_addr/_used        source operands of the ID instruction
//   PC_write, *_Reg_Write    stage enables (combinational)
//   IF/ID/EXE_Flush          bubble injection (combinational)
//   stall_timeout            sticky memory-wait watchdog flag
//   mem_stall_cnt, lu_stall_cnt, flush_cnt   wrapping perf counters
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IM_stall,
    input  logic              DM_stall,
    input  logic              EXE_busy,
    input  logic              EXE_mispredict,
    input  logic              EXE_MemRead,
    input  logic [ADDR_W-1:0] EXE_rd_addr,
    input  logic [ADDR_W-1:0] ID_rs1_addr,
    input  logic [ADDR_W-1:0] ID_rs2_addr,
    input  logic              ID_rs1_used,
    input  logic              ID_rs2_used,
    output logic              PC_write,
    output logic              IF_ID_Reg_Write,
    output logic              IF_Flush,
    output logic              ID_EXE_Reg_Write,
    output logic              ID_Flush,
    output logic              EXE_MEM_Reg_Write,
    output logic              EXE_Flush,
    output logic              MEM_WB_Reg_Write,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  mem_stall_cnt,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t             state_q, state_d;
    logic               flush_pend_q, flush_pend_d;
    logic               stall_timeout_q, stall_timeout_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   mem_stall_cnt_q, mem_stall_cnt_d;
    logic [CNT_W-1:0]   lu_stall_cnt_q, lu_stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               mem_stall;
    logic               load_use;
    logic               redirect;
    logic [WAIT_W-1:0]  cur_wait;

    assign mem_stall = IM_stall | DM_stall;
    assign load_use  = EXE_MemRead && (EXE_rd_addr != '0) &&
                       ((ID_rs1_used && (ID_rs1_addr == EXE_rd_addr)) ||
                        (ID_rs2_used && (ID_rs2_addr == EXE_rd_addr)));
    assign redirect  = EXE_mispredict | flush_pend_q;

    // Consecutive stall cycles already seen; a fresh stall from RUN starts at 0.
    assign cur_wait  = (state_q == MEM_WAIT) ? wait_cnt_q : '0;

    // Stage controls, zero latency. Forced inactive while reset is held so
    // nothing in the pipeline moves during an asynchronous reset.
    always_comb begin
        PC_write          = 1'b1;
        IF_ID_Reg_Write   = 1'b1;
        IF_Flush          = 1'b0;
        ID_EXE_Reg_Write  = 1'b1;
        ID_Flush          = 1'b0;
        EXE_MEM_Reg_Write = 1'b1;
        EXE_Flush         = 1'b0;
        MEM_WB_Reg_Write  = 1'b1;
        if (rst || mem_stall) begin
            PC_write          = 1'b0;
            IF_ID_Reg_Write   = 1'b0;
            ID_EXE_Reg_Write  = 1'b0;
            EXE_MEM_Reg_Write = 1'b0;
            MEM_WB_Reg_Write  = 1'b0;
        end else if (redirect) begin
            // IF and ID hold wrong-path instructions; EXE's branch proceeds.
            IF_Flush = 1'b1;
            ID_Flush = 1'b1;
        end else if (EXE_busy) begin
            PC_write         = 1'b0;
            IF_ID_Reg_Write  = 1'b0;
            ID_EXE_Reg_Write = 1'b0;
            EXE_Flush        = 1'b1;
        end else if (load_use) begin
            PC_write        = 1'b0;
            IF_ID_Reg_Write = 1'b0;
            ID_Flush        = 1'b1;
        end
    end

    // Next-state: FSM, pending flush, watchdog and counters.
    always_comb begin
        state_d         = state_q;
        flush_pend_d    = flush_pend_q;
        stall_timeout_d = stall_timeout_q;
        wait_cnt_d      = '0;
        mem_stall_cnt_d = mem_stall_cnt_q;
        lu_stall_cnt_d  = lu_stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;

        case (state_q)
            RUN:      if (mem_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (mem_stall) begin
            mem_stall_cnt_d = mem_stall_cnt_q + CNT_ONE;
            // A mispredict seen during a freeze is remembered and applied on
            // the first non-stalled cycle.
            if (EXE_mispredict) flush_pend_d = 1'b1;
            if (cur_wait == WAIT_LAST) stall_timeout_d = 1'b1;
            // Saturate so a very long stall never wraps the run length.
            wait_cnt_d = (cur_wait == WAIT_LAST) ? cur_wait : cur_wait + WAIT_ONE;
        end else if (redirect) begin
            flush_pend_d = 1'b0;
            flush_cnt_d  = flush_cnt_q + CNT_ONE;
        end else if (!EXE_busy && load_use) begin
            lu_stall_cnt_d = lu_stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            flush_pend_q    <= 1'b0;
            stall_timeout_q <= 1'b0;
            wait_cnt_q      <= '0;
            mem_stall_cnt_q <= '0;
            lu_stall_cnt_q  <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            flush_pend_q    <= flush_pend_d;
            stall_timeout_q <= stall_timeout_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
            lu_stall_cnt_q  <= lu_stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign stall_timeout = stall_timeout_q;
    assign mem_stall_cnt = mem_stall_cnt_q;
    assign lu_stall_cnt  = lu_stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule
